// File: rtl/karatsuba_split_issuer_142bit.sv
// Splits one 142x142 GF(2) multiply job into three 71-bit sub-jobs (low, middle, high)
// and issues them in order to a shared sub-multiplier over a valid/ready handshake.
module karatsuba_split_issuer_142bit #(
  parameter int unsigned N     = 142,
  parameter int unsigned M     = 71,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             sub_valid,
  input  logic             sub_ready,
  output logic [M-1:0]     sub_a,
  output logic [M-1:0]     sub_b,
  output logic [1:0]       sub_tag,
  output logic             sub_last,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_MID  = 2'd2,
    S_HI   = 2'd3
  } state_t;

  localparam logic [1:0] TAG_LO  = 2'd0;
  localparam logic [1:0] TAG_MID = 2'd1;
  localparam logic [1:0] TAG_HI  = 2'd2;

  typedef struct packed {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [1:0]   tag;
    logic         last;
  } sub_job_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  sub_job_t         r_sub;
  sub_job_t         w_sub_nxt;
  logic             r_sub_valid;
  logic             w_sub_valid_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic [CNT_W-1:0] r_op_count;
  logic [CNT_W-1:0] w_op_count_nxt;
  logic             w_in_ready;
  logic             w_in_xfer;
  logic             w_sub_xfer;
  logic [N-1:0]     w_a_src;
  logic [N-1:0]     w_b_src;

  // Next state and next registered sub-job; the payload is rebuilt from the operands
  // feeding the next state, so it stays stable while a sub-job is stalled.
  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready      = 1'b0;
    w_op_count_nxt  = r_op_count;
    w_sub_nxt       = '0;
    w_sub_valid_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    w_a_src         = r_a;
    w_b_src         = r_b;
    w_sub_xfer      = r_sub_valid && sub_ready;

    case (r_state)
      S_IDLE:  w_in_ready = rst_n;
      S_HI:    w_in_ready = rst_n && sub_ready;
      default: w_in_ready = 1'b0;
    endcase

    w_in_xfer = in_valid && w_in_ready;
    if (w_in_xfer) begin
      w_a_src = in_a;
      w_b_src = in_b;
    end

    case (r_state)
      S_IDLE: begin
        if (w_in_xfer) w_state_nxt = S_LO;
      end
      S_LO: begin
        if (w_sub_xfer) w_state_nxt = S_MID;
      end
      S_MID: begin
        if (w_sub_xfer) w_state_nxt = S_HI;
      end
      S_HI: begin
        if (w_sub_xfer) begin
          w_op_count_nxt = r_op_count + CNT_W'(1);
          w_state_nxt    = w_in_xfer ? S_LO : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_LO: begin
        w_sub_nxt.a   = w_a_src[M-1:0];
        w_sub_nxt.b   = w_b_src[M-1:0];
        w_sub_nxt.tag = TAG_LO;
      end
      S_MID: begin
        w_sub_nxt.a   = w_a_src[M-1:0] ^ w_a_src[N-1:M];
        w_sub_nxt.b   = w_b_src[M-1:0] ^ w_b_src[N-1:M];
        w_sub_nxt.tag = TAG_MID;
      end
      S_HI: begin
        w_sub_nxt.a    = w_a_src[N-1:M];
        w_sub_nxt.b    = w_b_src[N-1:M];
        w_sub_nxt.tag  = TAG_HI;
        w_sub_nxt.last = 1'b1;
      end
      default: w_sub_nxt = '0;
    endcase

    w_sub_valid_nxt = (w_state_nxt != S_IDLE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  // State, latched operands and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= '0;
      r_sub_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_op_count  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sub       <= w_sub_nxt;
      r_sub_valid <= w_sub_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_op_count  <= w_op_count_nxt;
      if (w_in_xfer) begin
        r_a <= in_a;
        r_b <= in_b;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign sub_valid = r_sub_valid;
  assign sub_a     = r_sub.a;
  assign sub_b     = r_sub.b;
  assign sub_tag   = r_sub.tag;
  assign sub_last  = r_sub.last;
  assign busy      = r_busy;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_karatsuba_split_issuer_142bit.sv
// Bench for the Karatsuba split issuer: queue-based model of pending sub-jobs plus directed
// literal checks, followed by randomized jobs with random sub-multiplier backpressure.
module tb_karatsuba_split_issuer_142bit;

  localparam int unsigned N     = 142;
  localparam int unsigned M     = 71;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned CW_S  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             sub_ready = 1'b0;
  logic [N-1:0]     in_a = '0;
  logic [N-1:0]     in_b = '0;
  logic             in_ready;
  logic             sub_valid;
  logic [M-1:0]     sub_a;
  logic [M-1:0]     sub_b;
  logic [1:0]       sub_tag;
  logic             sub_last;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  logic             in_ready_s;
  logic             sub_valid_s;
  logic [M-1:0]     sub_a_s;
  logic [M-1:0]     sub_b_s;
  logic [1:0]       sub_tag_s;
  logic             sub_last_s;
  logic             busy_s;
  logic [CW_S-1:0]  op_count_s;

  karatsuba_split_issuer_142bit #(.N(N), .M(M), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .sub_valid(sub_valid), .sub_ready(sub_ready),
    .sub_a(sub_a), .sub_b(sub_b), .sub_tag(sub_tag), .sub_last(sub_last),
    .busy(busy), .op_count(op_count)
  );

  // Narrow-counter copy so counter wrap is reached within a short run.
  karatsuba_split_issuer_142bit #(.N(N), .M(M), .CNT_W(CW_S)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .sub_valid(sub_valid_s), .sub_ready(sub_ready),
    .sub_a(sub_a_s), .sub_b(sub_b_s), .sub_tag(sub_tag_s), .sub_last(sub_last_s),
    .busy(busy_s), .op_count(op_count_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [1:0]   tag;
  } exp_t;

  exp_t        q[$];
  int unsigned done_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rand_op();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[N-1:0];
  endfunction

  task automatic push_job(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.a = a[M-1:0];               e.b = b[M-1:0];               e.tag = 2'd0; q.push_back(e);
    e.a = a[M-1:0] ^ a[N-1:M];    e.b = b[M-1:0] ^ b[N-1:M];    e.tag = 2'd1; q.push_back(e);
    e.a = a[N-1:M];               e.b = b[N-1:M];               e.tag = 2'd2; q.push_back(e);
  endtask

  task automatic check_outputs();
    logic pend;
    pend = (q.size() != 0);
    check("sub_valid", sub_valid, pend);
    check("busy", busy, pend);
    check("op_count", op_count, CNT_W'(done_cnt));
    check("small_sub_valid", sub_valid_s, pend);
    check("small_op_count", op_count_s, CW_S'(done_cnt));
    if (pend) begin
      check("sub_a", sub_a, q[0].a);
      check("sub_b", sub_b, q[0].b);
      check("sub_tag", sub_tag, q[0].tag);
      check("sub_last", sub_last, q[0].tag == 2'd2);
    end
  endtask

  // One clock: drive at the falling edge, check in_ready, advance the model, check outputs.
  task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic sr, input logic rn, output logic rdy);
    logic exp_rdy;
    exp_t tmp;
    in_valid = v; in_a = a; in_b = b; sub_ready = sr; rst_n = rn;
    #1;
    exp_rdy = rn && ((q.size() == 0) || (q.size() == 1 && sr));
    check("in_ready", in_ready, exp_rdy);
    rdy = in_ready;
    if (!rn) begin
      q.delete();
      done_cnt = 0;
    end else begin
      if (q.size() != 0 && sr) begin
        tmp = q.pop_front();
        if (tmp.tag == 2'd2) done_cnt++;
      end
      if (v && exp_rdy) push_job(a, b);
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic         rdy;
    logic [N-1:0] j1, j2, ca, cb;
    logic         offering;
    int           cycles;

    @(negedge clk);
    step(1'b1, '1, '1, 1'b1, 1'b0, rdy);
    step(1'b0, '0, '0, 1'b0, 1'b0, rdy);
    check("rst_in_ready", rdy, 1'b0);
    check("rst_sub_a", sub_a, '0);
    check("rst_sub_b", sub_b, '0);
    check("rst_tag_last", {sub_tag, sub_last}, '0);

    // Basic split with hand-computed sub-operands.
    step(1'b1, {71'd1, 71'd5}, {71'd3, 71'd9}, 1'b1, 1'b1, rdy);
    check("lit_lo", {sub_a, sub_b, sub_tag, sub_last}, {71'd5, 71'd9, 2'd0, 1'b0});
    step(1'b0, '0, '0, 1'b1, 1'b1, rdy);
    check("lit_mid", {sub_a, sub_b, sub_tag, sub_last}, {71'd4, 71'd10, 2'd1, 1'b0});
    step(1'b0, '0, '0, 1'b1, 1'b1, rdy);
    check("lit_hi", {sub_a, sub_b, sub_tag, sub_last}, {71'd1, 71'd3, 2'd2, 1'b1});
    step(1'b0, '0, '0, 1'b1, 1'b1, rdy);
    check("lit_basic_done", {busy, op_count}, {1'b0, 16'd1});

    // Backpressure in the middle sub-job; live operand changes must not be captured.
    step(1'b1, '1, '0, 1'b1, 1'b1, rdy);
    step(1'b0, '0, '0, 1'b1, 1'b1, rdy);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, rand_op(), rand_op(), 1'b0, 1'b1, rdy);
      check("lit_bp_ready", rdy, 1'b0);
      check("lit_bp_hold", {sub_valid, sub_a, sub_b, sub_tag}, {1'b1, 71'd0, 71'd0, 2'd1});
    end
    step(1'b1, rand_op(), rand_op(), 1'b1, 1'b1, rdy);
    check("lit_bp_hi", {sub_a, sub_b, sub_tag}, {{71{1'b1}}, 71'd0, 2'd2});
    step(1'b0, '0, '0, 1'b1, 1'b1, rdy);

    // Back-to-back jobs with zero bubbles.
    j1 = rand_op(); j2 = rand_op();
    step(1'b1, j1, j1, 1'b1, 1'b1, rdy); check("lit_b2b_rdy1", rdy, 1'b1); check("lit_b2b_tag1", sub_tag, 2'd0);
    step(1'b1, j2, j2, 1'b1, 1'b1, rdy); check("lit_b2b_rdy2", rdy, 1'b0); check("lit_b2b_tag2", sub_tag, 2'd1);
    step(1'b1, j2, j2, 1'b1, 1'b1, rdy); check("lit_b2b_rdy3", rdy, 1'b0); check("lit_b2b_tag3", sub_tag, 2'd2);
    step(1'b1, j2, j2, 1'b1, 1'b1, rdy); check("lit_b2b_rdy4", rdy, 1'b1); check("lit_b2b_tag4", sub_tag, 2'd0);
    step(1'b0, '0, '0, 1'b1, 1'b1, rdy); check("lit_b2b_tag5", sub_tag, 2'd1);
    step(1'b0, '0, '0, 1'b1, 1'b1, rdy); check("lit_b2b_tag6", sub_tag, 2'd2);
    step(1'b0, '0, '0, 1'b1, 1'b1, rdy); check("lit_b2b_rdy7", rdy, 1'b1);
    check("lit_b2b_done", {sub_valid, op_count}, {1'b0, 16'd4});

    // Reset while the middle sub-job is pending discards the rest of the job.
    step(1'b1, rand_op(), rand_op(), 1'b1, 1'b1, rdy);
    step(1'b0, '0, '0, 1'b1, 1'b1, rdy);
    step(1'b0, '0, '0, 1'b1, 1'b0, rdy);
    check("lit_rst_mid", {sub_valid, busy, op_count, sub_a, sub_b, sub_tag, sub_last}, '0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b1, rdy);
      check("lit_rst_no_issue", sub_valid, 1'b0);
    end

    // Random jobs with random backpressure; upstream holds each offer until accepted.
    offering = 1'b0; ca = '0; cb = '0; cycles = 0;
    while (done_cnt < 1000 && cycles < 20000) begin
      if (!offering && ($urandom_range(0, 1) == 1)) begin
        offering = 1'b1; ca = rand_op(); cb = rand_op();
      end
      step(offering, ca, cb, ($urandom_range(0, 3) != 0), 1'b1, rdy);
      if (offering && rdy) offering = 1'b0;
      cycles++;
    end
    check("random_jobs_done", (done_cnt >= 1000), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/karatsuba_split_issuer_142bit.md
Name: karatsuba_split_issuer_142bit

Overview:
- Operand-side counterpart of the 142-bit overlap stage. Accepts one 142x142 GF(2) multiplication job per handshake and splits each operand into 71-bit halves.
- Issues three sub-multiplication jobs in fixed order to a shared 71-bit sub-multiplier: low, middle, high. These produce the three 141-bit products that the overlap stage recombines into 283 bits.
- Sits between the top-level 283-bit multiplier controller and the 71-bit sub-multiplier.

Parameters:
- N, 142, full operand width.
- M, 71, half width (N/2); N must be even.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  job offer from upstream
- in_ready  output  1  issuer can accept a job this cycle
- in_a  input  N  operand A; A0 = in_a[M-1:0], A1 = in_a[N-1:M]
- in_b  input  N  operand B; B0 = in_b[M-1:0], B1 = in_b[N-1:M]
- sub_valid  output  1  sub-job present on sub_a/sub_b
- sub_ready  input  1  sub-multiplier accepts the sub-job
- sub_a  output  M  sub-operand A
- sub_b  output  M  sub-operand B
- sub_tag  output  2  0 = low (A0,B0), 1 = middle (A0^A1,B0^B1), 2 = high (A1,B1); 3 is never driven
- sub_last  output  1  high with tag 2
- busy  output  1  a job is held (state != IDLE)
- op_count  output  CNT_W  count of fully issued jobs

Behaviour:
- Handshakes: transfer occurs on a cycle where valid && ready is sampled at the rising edge. in_a/in_b are captured only on an input transfer.
- Output stability: sub_valid, sub_a, sub_b, sub_tag and sub_last are registered. While sub_valid=1 && sub_ready=0 they hold stable; sub_valid never drops without a transfer (except on reset).
- FSM states:
  - IDLE: sub_valid=0. On input transfer, latch A/B and go to LO.
  - LO: drives tag 0, sub_a=A0, sub_b=B0. On transfer go to MID.
  - MID: drives tag 1, sub_a=A0^A1, sub_b=B0^B1. On transfer go to HI.
  - HI: drives tag 2, sub_last=1, sub_a=A1, sub_b=B1. On transfer, op_count increments. If an input transfer also occurs in the same cycle, go to LO with the new operands; otherwise go to IDLE.
- in_ready = rst_n && (state==IDLE || (state==HI && sub_ready)). It is combinational from state and sub_ready, never from in_valid.
- Latency: input transfer at edge t gives sub_valid=1, tag 0 after edge t.
- Throughput: with sub_ready held high, three cycles per job and zero bubbles between back-to-back jobs.
- Operand holding: latched operands are held unchanged until the tag-2 transfer. The middle XOR is computed from latched operands, never from live in_a/in_b.
- op_count wraps from 2^CNT_W-1 to 0.
- Reset (rst_n=0 at an edge): state=IDLE, sub_valid=0, sub_a=0, sub_b=0, sub_tag=0, sub_last=0, busy=0, op_count=0, latched operands=0. in_ready=0 while rst_n=0.
- Reset mid-job: remaining sub-jobs are discarded and not issued after reset deasserts. op_count does not count the aborted job.
- in_valid in states LO or MID: ignored, no capture. Upstream must hold the offer.
- sub_ready while sub_valid=0: no effect.

Test Plan:
- Basic split: in_a={71'd1,71'd5}, in_b={71'd3,71'd9}, sub_ready=1 -> sub-jobs (5,9,tag0), (4,10,tag1), (1,3,tag2,last=1) on 3 consecutive cycles; op_count=1; busy falls the cycle after the tag-2 transfer.
- Back-to-back: two jobs offered continuously with sub_ready=1 -> 6 consecutive sub_valid cycles with tags 0,1,2,0,1,2; in_ready=1 only in IDLE and HI cycles; op_count=2.
- Backpressure: sub_ready=0 for 4 cycles during MID with in_a all-ones, in_b=0 -> sub_a=0, sub_b=0, tag 1 held stable all 4 cycles; in_ready=0 throughout; operands changed on in_a meanwhile are not captured.
- Reset mid-job: assert rst_n=0 while in MID -> next cycle all outputs 0 and op_count=0; after release, no tag-2 issue occurs until a new input transfer.
- Counter wrap: preload by issuing 65535 jobs (or force op_count=16'hFFFF) then complete one job -> op_count=0.
- Tag integrity: random 1000 jobs with random sub_ready -> each job produces exactly tags 0,1,2 in order. Sub-operands match A0/B0, A0^A1/B0^B1, A1/B1 against a reference model. Tag 3 is never seen.
